// File: rtl/i2c_cfg_responder.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_cfg_responder
//  Purpose  : I2C target emulating an 8-byte 24-series EEPROM config page,
//             with local preload (i_load) and observation (o_page_data).
//  Revision : 1.0  initial release
// ============================================================================
module i2c_cfg_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_scl,
  input  logic        i_sda,
  output logic        o_sda,
  output logic        t_sda,
  input  logic        i_load,
  input  logic [63:0] i_page_data,
  output logic [63:0] o_page_data,
  output logic        o_wr_strobe,
  output logic [2:0]  o_wr_addr,
  output logic        o_busy
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV_ADDR  = 4'd1,
    ST_DEV_ACK   = 4'd2,
    ST_WORD_ADDR = 4'd3,
    ST_WORD_ACK  = 4'd4,
    ST_WR_DATA   = 4'd5,
    ST_WR_ACK    = 4'd6,
    ST_RD_DATA   = 4'd7,
    ST_RD_ACK    = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_t;

  logic [SYNC_N-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_N-1:0] sda_sync_q, sda_sync_d;
  logic              scl_prev_q, scl_prev_d;
  logic              sda_prev_q, sda_prev_d;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [2:0]  ptr_q, ptr_d;
  logic        rw_q, rw_d;
  logic [7:0]  rd_byte_q, rd_byte_d;
  logic        drv_q, drv_d;
  logic        busy_q, busy_d;
  logic [63:0] page_q, page_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [2:0]  wr_addr_q, wr_addr_d;

  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] sh_in;
  logic       last_bit;
  logic [2:0] ptr_inc;
  logic [7:0] byte_at_ptr, byte_at_next;

  assign scl_s     = scl_sync_q[SYNC_N-1];
  assign sda_s     = sda_sync_q[SYNC_N-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  assign sh_in        = {shift_q, sda_s};
  assign last_bit     = (bit_cnt_q == 4'd7);
  assign ptr_inc      = ptr_q + 3'd1;
  assign byte_at_ptr  = page_q[{ptr_q, 3'b000} +: 8];
  assign byte_at_next = page_q[{ptr_inc, 3'b000} +: 8];

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_N-2:0], i_scl};
    sda_sync_d = {sda_sync_q[SYNC_N-2:0], i_sda};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    rd_byte_d   = rd_byte_q;
    drv_d       = drv_q;
    busy_d      = busy_q;
    page_d      = page_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;

    if (start_det) begin
      state_d   = ST_DEV_ADDR;
      bit_cnt_d = 4'd0;
      drv_d     = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      drv_d     = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_DEV_ADDR: if (scl_rise) begin
          shift_d   = sh_in[6:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (last_bit) begin
            bit_cnt_d = 4'd0;
            if (sh_in[7:1] == DEV_ADDR) begin
              rw_d    = sh_in[0];
              busy_d  = 1'b1;
              state_d = ST_DEV_ACK;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_WAIT_STOP;
            end
          end
        end
        // ACK phases: first SCL fall starts driving low, second one ends the ACK clock.
        ST_DEV_ACK: if (scl_fall) begin
          if (!drv_q) begin
            drv_d = 1'b1;
          end else if (rw_q) begin
            state_d   = ST_RD_DATA;
            rd_byte_d = byte_at_ptr;
            drv_d     = ~byte_at_ptr[7];
            bit_cnt_d = 4'd0;
          end else begin
            state_d   = ST_WORD_ADDR;
            drv_d     = 1'b0;
          end
        end
        ST_WORD_ADDR: if (scl_rise) begin
          shift_d   = sh_in[6:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (last_bit) begin
            bit_cnt_d = 4'd0;
            ptr_d     = sh_in[2:0];
            state_d   = ST_WORD_ACK;
          end
        end
        ST_WORD_ACK, ST_WR_ACK: if (scl_fall) begin
          if (!drv_q) begin
            drv_d = 1'b1;
          end else begin
            drv_d   = 1'b0;
            state_d = ST_WR_DATA;
          end
        end
        ST_WR_DATA: if (scl_rise) begin
          shift_d   = sh_in[6:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (last_bit) begin
            bit_cnt_d                    = 4'd0;
            page_d[{ptr_q, 3'b000} +: 8] = sh_in;
            wr_strobe_d                  = 1'b1;
            wr_addr_d                    = ptr_q;
            ptr_d                        = ptr_inc;
            state_d                      = ST_WR_ACK;
          end
        end
        ST_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              drv_d     = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = ST_RD_ACK;
            end else begin
              drv_d = ~rd_byte_q[3'd7 - bit_cnt_q[2:0]];
            end
          end
        end
        // bit_cnt marks that the initiator ACKed and the next byte is latched.
        ST_RD_ACK: begin
          if (scl_rise && bit_cnt_q == 4'd0) begin
            ptr_d = ptr_inc;
            if (sda_s) begin
              drv_d   = 1'b0;
              state_d = ST_WAIT_STOP;
            end else begin
              bit_cnt_d = 4'd1;
              rd_byte_d = byte_at_next;
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            bit_cnt_d = 4'd0;
            drv_d     = ~rd_byte_q[7];
            state_d   = ST_RD_DATA;
          end
        end
        ST_WAIT_STOP: drv_d = 1'b0;
        default: begin
          state_d = ST_IDLE;
          drv_d   = 1'b0;
        end
      endcase
    end

    if (i_load) begin
      page_d = i_page_data;
    end
  end

  // Synchroniser resets to the idle-high bus level so release is not seen as an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 7'd0;
      ptr_q       <= 3'd0;
      rw_q        <= 1'b0;
      rd_byte_q   <= 8'd0;
      drv_q       <= 1'b0;
      busy_q      <= 1'b0;
      page_q      <= 64'd0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 3'd0;
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_prev_q  <= scl_prev_d;
      sda_prev_q  <= sda_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      rd_byte_q   <= rd_byte_d;
      drv_q       <= drv_d;
      busy_q      <= busy_d;
      page_q      <= page_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  assign o_sda       = 1'b0;
  assign t_sda       = ~drv_q;
  assign o_page_data = page_q;
  assign o_wr_strobe = wr_strobe_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_busy      = busy_q;

endmodule
`default_nettype wire
